// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: drives the PLL reset, qualifies the synchronised lock flag,
// releases the per-domain resets one by one and retries or faults on lock trouble.
module pll_lock_supervisor #(
  parameter int NUM_CLOCKS     = 2,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 10000,
  parameter int LOCK_STABLE    = 1000,
  parameter int STAGGER        = 4,
  parameter int MAX_RETRIES    = 3,
  parameter int RETRY_W        = 4
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  locked_in,
  input  logic                  relock_req,
  output logic                  pll_rst,
  output logic [NUM_CLOCKS-1:0] domain_rst,
  output logic                  ready,
  output logic                  fault,
  output logic [RETRY_W-1:0]    retry_count,
  output logic [15:0]           lock_loss_count
);

  // One shared timer; it must cover the longest interval any state measures.
  localparam int MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_B = (LOCK_STABLE > NUM_CLOCKS * STAGGER) ? LOCK_STABLE : NUM_CLOCKS * STAGGER;
  localparam int TMAX  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int TW    = $clog2(TMAX + 1);

  // Terminal timer values: the state exits on the edge where the timer holds these.
  localparam logic [TW-1:0]      RST_LAST  = TW'(PLL_RST_CYCLES - 1);
  localparam logic [TW-1:0]      TO_LAST   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0]      STB_LAST  = TW'(LOCK_STABLE - 1);
  localparam logic [TW-1:0]      REL_LAST  = TW'((NUM_CLOCKS - 1) * STAGGER);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET,
    S_WAIT_LOCK,
    S_STABLE,
    S_RELEASE,
    S_RUN,
    S_FAULT
  } state_t;

  state_t                state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [TW-1:0]         tinc;
  logic [1:0]            sync_q, sync_d;
  logic                  locked_s;
  logic                  pll_rst_q, pll_rst_d;
  logic [NUM_CLOCKS-1:0] domain_rst_q, domain_rst_d;
  logic                  ready_q, ready_d;
  logic                  fault_q, fault_d;
  logic [RETRY_W-1:0]    retry_count_q, retry_count_d;
  logic [15:0]           lock_loss_count_q, lock_loss_count_d;

  // Two-flop synchroniser shift for the asynchronous lock flag.
  always_comb begin
    sync_d = {sync_q[0], locked_in};
  end

  assign locked_s = sync_q[1];

  // Synchroniser flops.
  always_ff @(posedge refclk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  // Next-state and next-output decode; all outputs are held unless a branch changes them.
  always_comb begin
    state_d           = state_q;
    timer_d           = timer_q;
    tinc              = timer_q + TW'(1);
    pll_rst_d         = pll_rst_q;
    domain_rst_d      = domain_rst_q;
    ready_d           = ready_q;
    fault_d           = fault_q;
    retry_count_d     = retry_count_q;
    lock_loss_count_d = lock_loss_count_q;

    if (relock_req) begin
      // A requested relock wins over every other event and is never counted as a loss.
      state_d       = S_RESET;
      timer_d       = '0;
      pll_rst_d     = 1'b1;
      domain_rst_d  = '1;
      ready_d       = 1'b0;
      fault_d       = 1'b0;
      retry_count_d = '0;
    end else begin
      case (state_q)
        S_RESET: begin
          if (timer_q == RST_LAST) begin
            state_d   = S_WAIT_LOCK;
            timer_d   = '0;
            pll_rst_d = 1'b0;
          end else begin
            timer_d = tinc;
          end
        end

        S_WAIT_LOCK: begin
          if (locked_s) begin
            state_d = S_STABLE;
            timer_d = '0;
          end else if (timer_q == TO_LAST) begin
            timer_d   = '0;
            pll_rst_d = 1'b1;
            if (retry_count_q == RETRY_MAX) begin
              state_d = S_FAULT;
              fault_d = 1'b1;
            end else begin
              state_d       = S_RESET;
              retry_count_d = retry_count_q + RETRY_W'(1);
            end
          end else begin
            timer_d = tinc;
          end
        end

        S_STABLE: begin
          // A dropout here is a glitch, not a failed attempt: just restart the lock wait.
          if (!locked_s) begin
            state_d = S_WAIT_LOCK;
            timer_d = '0;
          end else if (timer_q == STB_LAST) begin
            state_d         = S_RELEASE;
            timer_d         = '0;
            domain_rst_d[0] = 1'b0;
          end else begin
            timer_d = tinc;
          end
        end

        S_RELEASE: begin
          if (!locked_s) begin
            state_d      = S_RESET;
            timer_d      = '0;
            pll_rst_d    = 1'b1;
            domain_rst_d = '1;
          end else if (timer_q == REL_LAST) begin
            state_d       = S_RUN;
            timer_d       = '0;
            ready_d       = 1'b1;
            retry_count_d = '0;
          end else begin
            timer_d = tinc;
            // Bit i drops once the timer reaches i*STAGGER; cleared bits stay cleared.
            for (int i = 0; i < NUM_CLOCKS; i++) begin
              if (tinc >= TW'(i * STAGGER)) domain_rst_d[i] = 1'b0;
            end
          end
        end

        S_RUN: begin
          if (!locked_s) begin
            state_d           = S_RESET;
            timer_d           = '0;
            pll_rst_d         = 1'b1;
            domain_rst_d      = '1;
            ready_d           = 1'b0;
            lock_loss_count_d = (lock_loss_count_q == 16'hFFFF) ? lock_loss_count_q
                                                                : lock_loss_count_q + 16'd1;
          end
        end

        S_FAULT: begin
          // Parked with the PLL held in reset until relock_req or rst.
        end

        default: begin
          state_d      = S_RESET;
          timer_d      = '0;
          pll_rst_d    = 1'b1;
          domain_rst_d = '1;
          ready_d      = 1'b0;
        end
      endcase
    end
  end

  // Supervisor state and registered outputs.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q           <= S_RESET;
      timer_q           <= '0;
      pll_rst_q         <= 1'b1;
      domain_rst_q      <= '1;
      ready_q           <= 1'b0;
      fault_q           <= 1'b0;
      retry_count_q     <= '0;
      lock_loss_count_q <= '0;
    end else begin
      state_q           <= state_d;
      timer_q           <= timer_d;
      pll_rst_q         <= pll_rst_d;
      domain_rst_q      <= domain_rst_d;
      ready_q           <= ready_d;
      fault_q           <= fault_d;
      retry_count_q     <= retry_count_d;
      lock_loss_count_q <= lock_loss_count_d;
    end
  end

  assign pll_rst         = pll_rst_q;
  assign domain_rst      = domain_rst_q;
  assign ready           = ready_q;
  assign fault           = fault_q;
  assign retry_count     = retry_count_q;
  assign lock_loss_count = lock_loss_count_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: fixed vector table, corner-case sequences and a
// randomized run, all checked every cycle against a phase/duration reference model.
module tb_pll_lock_supervisor;
  localparam int N = 2, P = 4, T = 32, S = 8, STG = 2, MAXR = 2, RW = 4;

  logic          refclk = 1'b0;
  logic          rst_i  = 1'b1;
  logic          lk_i   = 1'b0;
  logic          rl_i   = 1'b0;
  logic          pll_rst;
  logic [N-1:0]  domain_rst;
  logic          ready, fault;
  logic [RW-1:0] retry_count;
  logic [15:0]   lock_loss_count;

  int nvec  = 0;
  int nmiss = 0;

  pll_lock_supervisor #(
    .NUM_CLOCKS(N), .PLL_RST_CYCLES(P), .LOCK_TIMEOUT(T), .LOCK_STABLE(S),
    .STAGGER(STG), .MAX_RETRIES(MAXR), .RETRY_W(RW)
  ) dut (
    .refclk(refclk), .rst(rst_i), .locked_in(lk_i), .relock_req(rl_i),
    .pll_rst(pll_rst), .domain_rst(domain_rst), .ready(ready), .fault(fault),
    .retry_count(retry_count), .lock_loss_count(lock_loss_count)
  );

  always #5 refclk = ~refclk;

  // Reference model: current phase, the cycle it was entered, and how long each phase lasts.
  localparam int PH_RST = 0, PH_WAIT = 1, PH_STAB = 2, PH_REL = 3, PH_RUN = 4, PH_FLT = 5;
  int     m_ph    = PH_RST;
  longint cyc     = 0;
  longint m_t0    = 0;
  int     m_retry = 0;
  int     m_llc   = 0;
  bit     m_s1    = 1'b0;
  bit     m_s2    = 1'b0;

  task automatic enter(input int ph);
    m_ph = ph;
    m_t0 = cyc;
  endtask

  task automatic model_step();
    bit ls;
    int age;
    cyc++;
    age = int'(cyc - m_t0);
    ls  = m_s2;
    if (rst_i) begin
      enter(PH_RST);
      m_retry = 0; m_llc = 0; m_s1 = 1'b0; m_s2 = 1'b0;
    end else begin
      m_s2 = m_s1;
      m_s1 = lk_i;
      if (rl_i) begin
        enter(PH_RST);
        m_retry = 0;
      end else begin
        case (m_ph)
          PH_RST:  if (age == P) enter(PH_WAIT);
          PH_WAIT: if (ls) enter(PH_STAB);
                   else if (age == T) begin
                     if (m_retry == MAXR) enter(PH_FLT);
                     else begin m_retry++; enter(PH_RST); end
                   end
          PH_STAB: if (!ls) enter(PH_WAIT);
                   else if (age == S) enter(PH_REL);
                   else ;
          PH_REL:  if (!ls) enter(PH_RST);
                   else if (age == (N - 1) * STG + 1) begin enter(PH_RUN); m_retry = 0; end
                   else ;
          PH_RUN:  if (!ls) begin
                     if (m_llc < 65535) m_llc++;
                     enter(PH_RST);
                   end
          default: ;
        endcase
      end
    end
  endtask

  function automatic logic [24:0] exp_vec();
    logic [N-1:0] dr;
    int age;
    age = int'(cyc - m_t0);
    for (int i = 0; i < N; i++)
      dr[i] = !(m_ph == PH_RUN || (m_ph == PH_REL && age >= i * STG));
    return {(m_ph == PH_RST || m_ph == PH_FLT), dr, (m_ph == PH_RUN), (m_ph == PH_FLT),
            RW'(m_retry), 16'(m_llc)};
  endfunction

  function automatic logic [24:0] act_vec();
    return {pll_rst, domain_rst, ready, fault, retry_count, lock_loss_count};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmiss++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // One clock: model advances on the edge, outputs compared 1 time unit later.
  task automatic tick();
    @(posedge refclk);
    model_step();
    #1;
    chk($sformatf("model@%0d", cyc), {7'd0, act_vec()}, {7'd0, exp_vec()});
  endtask

  typedef struct {
    bit       rst;
    bit       lk;
    int       n;
    bit       pll;
    bit [1:0] dr;
    bit       rdy;
    bit       flt;
    int       rt;
    int       llc;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int n, hc, mode, den;

    // Normal lock, then a lock loss in RUN and the relock that follows.
    tbl[0]  = '{1, 0, 3, 1, 2'b11, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 3, 1, 2'b11, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 1, 0, 2'b11, 0, 0, 0, 0};
    tbl[3]  = '{0, 0, 5, 0, 2'b11, 0, 0, 0, 0};
    tbl[4]  = '{0, 1, 1, 0, 2'b11, 0, 0, 0, 0};
    tbl[5]  = '{0, 1, 9, 0, 2'b11, 0, 0, 0, 0};
    tbl[6]  = '{0, 1, 1, 0, 2'b10, 0, 0, 0, 0};
    tbl[7]  = '{0, 1, 1, 0, 2'b10, 0, 0, 0, 0};
    tbl[8]  = '{0, 1, 1, 0, 2'b00, 0, 0, 0, 0};
    tbl[9]  = '{0, 1, 1, 0, 2'b00, 1, 0, 0, 0};
    tbl[10] = '{0, 0, 1, 0, 2'b00, 1, 0, 0, 0};
    tbl[11] = '{0, 0, 1, 0, 2'b00, 1, 0, 0, 0};
    tbl[12] = '{0, 0, 1, 1, 2'b11, 0, 0, 0, 1};
    tbl[13] = '{0, 1, 4, 0, 2'b11, 0, 0, 0, 1};
    tbl[14] = '{0, 1, 11, 0, 2'b00, 0, 0, 0, 1};
    tbl[15] = '{0, 1, 1, 0, 2'b00, 1, 0, 0, 1};

    for (int k = 0; k < 16; k++) begin
      rst_i = tbl[k].rst;
      lk_i  = tbl[k].lk;
      repeat (tbl[k].n) tick();
      chk($sformatf("vec%0d", k), {7'd0, act_vec()},
          {7'd0, tbl[k].pll, tbl[k].dr, tbl[k].rdy, tbl[k].flt, RW'(tbl[k].rt), 16'(tbl[k].llc)});
    end

    // Glitch during STABLE: ready comes a full re-stabilisation later (23 edges, not 16).
    rl_i = 1'b1; tick(); rl_i = 1'b0;
    repeat (8) tick();
    lk_i = 1'b0; tick();
    lk_i = 1'b1; tick();
    n = 10;
    while (!ready && n < 60) begin
      tick(); n++;
      if (n == 19) chk("glitch_dr_held", {30'd0, domain_rst}, 32'b11);
    end
    chk("glitch_ready_edge", n, 23);

    // No lock at all: three 4-cycle PLL resets, retries 1 and 2, fault on the third timeout.
    lk_i = 1'b0; rl_i = 1'b1; tick(); rl_i = 1'b0;
    n = 0; hc = int'(pll_rst);
    while (!fault && n < 200) begin
      tick(); n++;
      if (!fault) hc += int'(pll_rst);
      if (n == 36) chk("retry_first", {28'd0, retry_count}, 1);
      if (n == 72) chk("retry_second", {28'd0, retry_count}, 2);
    end
    chk("fault_edge", n, 108);
    chk("pll_rst_high_cycles", hc, 12);
    repeat (10) tick();
    chk("fault_sticky", {30'd0, fault, pll_rst}, 32'b11);

    // relock_req leaves FAULT; in RUN it beats a simultaneous lock loss.
    lk_i = 1'b1; rl_i = 1'b1; tick(); rl_i = 1'b0;
    chk("fault_relock", {24'd0, fault, pll_rst, domain_rst, retry_count}, {24'd0, 8'b0111_0000});
    n = 0;
    while (!ready && n < 100) begin tick(); n++; end
    chk("relock_ready", {31'd0, ready}, 1);
    lk_i = 1'b0; tick(); tick();
    rl_i = 1'b1; tick(); rl_i = 1'b0;
    chk("relock_beats_loss", {13'd0, ready, domain_rst, lock_loss_count}, {13'd0, 1'b0, 2'b11, 16'd1});

    // Loss counter saturation.
    lk_i = 1'b1;
    n = 0;
    while (!ready && n < 100) begin tick(); n++; end
    chk("sat_ready", {31'd0, ready}, 1);
    force dut.lock_loss_count_q = 16'hFFFF;
    m_llc = 65535;
    tick(); tick();
    release dut.lock_loss_count_q;
    tick();
    chk("llc_preset", {16'd0, lock_loss_count}, 32'hFFFF);
    lk_i = 1'b0;
    repeat (3) tick();
    chk("llc_saturates", {15'd0, ready, lock_loss_count}, {15'd0, 1'b0, 16'hFFFF});

    // rst in the middle of RELEASE restores every reset value at that edge.
    lk_i = 1'b1;
    n = 0;
    while (domain_rst !== 2'b10 && n < 200) begin tick(); n++; end
    chk("reach_release", {30'd0, domain_rst}, 32'b10);
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    chk("rst_mid_release", {7'd0, act_vec()}, {7'd0, 1'b1, 2'b11, 1'b0, 1'b0, 4'd0, 16'd0});

    // Randomized run in epochs of differing lock behaviour.
    mode = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 400 == 0) mode = int'($urandom_range(0, 2));
      den = (mode == 0) ? 64 : (mode == 1) ? 4 : 400;
      if ($urandom_range(0, den - 1) == 0) lk_i = ~lk_i;
      rl_i  = ($urandom_range(0, 249) == 0);
      rst_i = ($urandom_range(0, 1499) == 0);
      tick();
    end
    rl_i = 1'b0; rst_i = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
    $finish;
  end

endmodule
